// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundles the instruction-memory req/gnt/rvalid bus and the
//                decode-side valid/ready handshake of the fetch stage.
//                master : fetch unit side (drives req/addr and queue head)
//                slave  : memory + decode side (drives gnt/rvalid/rdata/ready)
//  Signals     : imem_req, imem_addr[ADDR_W], imem_gnt, imem_rvalid,
//                imem_rdata[INSTR_W], instr_valid, instr[INSTR_W],
//                instr_pc[ADDR_W], instr_ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the fetch PC, issues single
//                outstanding requests to instruction memory, buffers returned
//                words tagged with their PC in a DEPTH-entry prefetch queue
//                and redirects on taken branches (target = pc + 1 + sext(off)).
//  Ports       : clk             - clock, rising edge
//                rst_n           - asynchronous active-low reset
//                bus             - fetch_unit_if.master (imem bus + decode)
//                branch_taken_i  - one-cycle redirect strobe
//                branch_pc_i     - PC of the branch instruction
//                branch_offset_i - signed word offset
//                fetch_pc_o      - current fetch PC (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                OFFSET_W = 4,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    fetch_unit_if.master             bus,
    input  wire logic                branch_taken_i,
    input  wire logic [ADDR_W-1:0]   branch_pc_i,
    input  wire logic [OFFSET_W-1:0] branch_offset_i,
    output logic      [ADDR_W-1:0]   fetch_pc_o
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               outstanding_q, outstanding_d;
    logic               discard_q, discard_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic [ADDR_W-1:0]  sext_off;
    logic [ADDR_W-1:0]  target;
    logic               req;
    logic               grant;
    logic               resp;
    logic               push;
    logic               pop;

    assign sext_off = {{(ADDR_W-OFFSET_W){branch_offset_i[OFFSET_W-1]}}, branch_offset_i};
    assign target   = branch_pc_i + ADDR_W'(1) + sext_off;

    // Requests need a free slot so a returning word can always be pushed.
    // rst_n gating keeps the request low for the whole reset interval.
    assign req   = rst_n & ~outstanding_q & (count_q != FULL_CNT) & ~branch_taken_i;
    assign grant = req & bus.imem_gnt;
    assign resp  = outstanding_q & bus.imem_rvalid;
    // A response landing in a redirect cycle or flagged stale is dropped.
    assign push  = resp & ~discard_q & ~branch_taken_i;
    assign pop   = (count_q != '0) & bus.instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (grant) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        end

        if (resp) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end

        if (branch_taken_i) begin
            fetch_pc_d = target;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Still waiting on a response that belongs to the old path:
            // remember to throw it away when it finally arrives.
            discard_d  = outstanding_q & ~bus.imem_rvalid;
        end else begin
            case ({push, pop})
                2'b10: begin
                    count_d  = count_q + CNT_W'(1);
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                2'b01: begin
                    count_d  = count_q - CNT_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                2'b11: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage carries no reset; entries are only visible via count.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = instr_mem_q[rd_ptr_q];
    assign bus.instr_pc    = pc_mem_q[rd_ptr_q];
    assign fetch_pc_o      = fetch_pc_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. dut_a (RESET_PC=0) is
//                driven by a randomisable memory responder and tracked by a
//                queue-based reference model; dut_w (RESET_PC=0xFFFE) checks
//                PC wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    localparam int ADDR_W   = 16;
    localparam int INSTR_W  = 16;
    localparam int OFFSET_W = 4;
    localparam int DEPTH    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  = 1'b1;
    logic        br     = 1'b0;
    logic [15:0] br_pc  = '0;
    logic [3:0]  br_off = '0;
    logic        gnt    = 1'b1;
    logic        rvalid = 1'b0;
    logic [15:0] rdata  = '0;
    logic        ready  = 1'b0;
    logic [15:0] fpc_a, fpc_w;
    logic        rvalid_w = 1'b0;
    logic [15:0] rdata_w  = '0;

    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_a ();
    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_w ();

    assign bus_a.imem_gnt    = gnt;
    assign bus_a.imem_rvalid = rvalid;
    assign bus_a.imem_rdata  = rdata;
    assign bus_a.instr_ready = ready;
    assign bus_w.imem_gnt    = 1'b1;
    assign bus_w.imem_rvalid = rvalid_w;
    assign bus_w.imem_rdata  = rdata_w;
    assign bus_w.instr_ready = 1'b1;

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OFFSET_W(OFFSET_W),
                 .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .branch_taken_i(br), .branch_pc_i(br_pc), .branch_offset_i(br_off),
        .fetch_pc_o(fpc_a));

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OFFSET_W(OFFSET_W),
                 .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w),
        .branch_taken_i(1'b0), .branch_pc_i(16'h0000), .branch_offset_i(4'h0),
        .fetch_pc_o(fpc_w));

    int n_cmp = 0;
    int n_err = 0;

    // memory content: word at address a
    function automatic logic [15:0] f(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    function automatic logic [15:0] tgt(input logic [15:0] bpc, input logic [3:0] off);
        int o;
        logic [15:0] r;
        o = (off >= 4'd8) ? int'(off) - 16 : int'(off);
        r = 16'(int'(bpc) + 1 + o);
        return r;
    endfunction

    // ---------------- responder knobs / state ----------------
    int          gnt_rand = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    logic        s_req;
    logic [15:0] s_addr;
    logic        pend = 1'b0;
    logic [15:0] paddr;
    int          dly;

    // ---------------- reference model state ----------------
    logic [15:0] q_pc[$];
    logic        out_m  = 1'b0;
    logic [15:0] rpc_m  = '0;
    int          ep     = 0;
    int          req_ep = 0;
    logic [15:0] pc_m   = 16'h0000;

    // Memory responder + reference model for dut_a, stepped once per edge.
    initial begin
        logic req_m, pop_m, ok;
        forever begin
            @(negedge clk);
            #4;
            s_req  = bus_a.imem_req;
            s_addr = bus_a.imem_addr;
            @(posedge clk);
            if (!rst_n) begin
                q_pc.delete();
                out_m = 1'b0;
                pc_m  = 16'h0000;
                ep++;
                pend  = 1'b0;
            end else begin
                req_m = !out_m && (q_pc.size() < DEPTH) && !br;
                pop_m = (q_pc.size() != 0) && ready;
                ok    = 1'b0;
                if (rvalid && out_m) begin
                    out_m = 1'b0;
                    ok    = (req_ep == ep) && !br;
                end
                if (br) begin
                    q_pc.delete();
                    pc_m = tgt(br_pc, br_off);
                    ep++;
                end else begin
                    if (pop_m) void'(q_pc.pop_front());
                    if (ok) q_pc.push_back(rpc_m);
                    if (req_m && gnt) begin
                        out_m  = 1'b1;
                        rpc_m  = pc_m;
                        req_ep = ep;
                        pc_m   = pc_m + 16'd1;
                    end
                end
                if (s_req && gnt) begin
                    pend  = 1'b1;
                    paddr = s_addr;
                    dly   = $urandom_range(lat_max, lat_min) - 1;
                end
            end
            #1;
            if (!rst_n) begin
                rvalid = 1'b0;
            end else if (pend && dly == 0) begin
                rvalid = 1'b1;
                rdata  = f(paddr);
                pend   = 1'b0;
            end else begin
                rvalid = 1'b0;
                if (pend) dly--;
            end
            gnt = (gnt_rand != 0) ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // Fixed one-cycle responder for dut_w.
    initial begin
        logic sw_req;
        logic [15:0] sw_addr;
        forever begin
            @(negedge clk);
            #4;
            sw_req  = bus_w.imem_req;
            sw_addr = bus_w.imem_addr;
            @(posedge clk);
            #1;
            if (rst_n && sw_req) begin
                rvalid_w = 1'b1;
                rdata_w  = f(sw_addr);
            end else begin
                rvalid_w = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers (stimulus / recording only) ----------------
    logic [15:0] got_pc [8];
    logic [15:0] got_ins[8];
    int          got_n;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        br    = 1'b0;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic collect(input int n, input int budget);
        got_n = 0;
        for (int c = 0; c < budget && got_n < n; c++) begin
            if (bus_a.instr_valid && ready) begin
                got_pc[got_n]  = bus_a.instr_pc;
                got_ins[got_n] = bus_a.instr;
                got_n++;
            end
            if (got_n < n) @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        gnt_rand = 0; lat_min = 1; lat_max = 1;
        @(negedge clk);
        rst_n = 1'b0;
        ready = 1'b1;
        #1;
        n_cmp++; if (fpc_a !== 16'h0000) begin n_err++; $display("FAIL reset_pc: got %h required 0000", fpc_a); end
        n_cmp++; if (bus_a.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b required 0", bus_a.imem_req); end
        n_cmp++; if (bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", bus_a.instr_valid); end
        n_cmp++; if (fpc_w !== 16'hFFFE) begin n_err++; $display("FAIL reset_pc_w: got %h required fffe", fpc_w); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got valid=%b required 0", bus_a.instr_valid); end
        @(negedge clk);
        n_cmp++; if (bus_a.instr_valid !== 1'b1) begin n_err++; $display("FAIL latency_first: got valid=%b required 1", bus_a.instr_valid); end
        collect(3, 30);
        n_cmp++;
        if (got_n != 3) begin
            n_err++; $display("FAIL reset_seq_count: got %0d required 3", got_n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got_pc[i] !== 16'(i) || got_ins[i] !== 16'(16'h1000 + i)) begin
                    n_err++;
                    $display("FAIL reset_seq[%0d]: got {%h,%h} required {%h,%h}", i, got_ins[i], got_pc[i], 16'(16'h1000 + i), 16'(i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        gnt_rand = 0; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (20) @(negedge clk);
        n_cmp++; if (bus_a.imem_req !== 1'b0) begin n_err++; $display("FAIL full_req: got %b required 0", bus_a.imem_req); end
        n_cmp++; if (fpc_a !== 16'd4) begin n_err++; $display("FAIL full_pc: got %h required 0004", fpc_a); end
        n_cmp++; if (bus_a.instr_valid !== 1'b1 || bus_a.instr_pc !== 16'd0) begin
            n_err++; $display("FAIL full_head: got valid=%b pc=%h required 1/0000", bus_a.instr_valid, bus_a.instr_pc); end
        ready = 1'b1;
        collect(5, 60);
        n_cmp++;
        if (got_n != 5) begin
            n_err++; $display("FAIL drain_count: got %0d required 5", got_n);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (got_pc[i] !== 16'(i) || got_ins[i] !== f(16'(i))) begin
                    n_err++; $display("FAIL drain[%0d]: got pc=%h instr=%h required pc=%h", i, got_pc[i], got_ins[i], 16'(i));
                end
            end
        end
    endtask

    task automatic test_branch();
        gnt_rand = 0; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (4) @(negedge clk);   // two entries queued, nothing outstanding
        #1;
        br = 1'b1; br_pc = 16'd5; br_off = 4'b1110;
        #1;
        n_cmp++; if (bus_a.imem_req !== 1'b0) begin n_err++; $display("FAIL br_req: got %b required 0", bus_a.imem_req); end
        @(posedge clk);
        #1 br = 1'b0;
        @(negedge clk);
        n_cmp++; if (fpc_a !== 16'd4) begin n_err++; $display("FAIL br_pc: got %h required 0004", fpc_a); end
        n_cmp++; if (bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL br_flush: got %b required 0", bus_a.instr_valid); end
        n_cmp++; if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 16'd4) begin
            n_err++; $display("FAIL br_refetch: got req=%b addr=%h required 1/0004", bus_a.imem_req, bus_a.imem_addr); end
        ready = 1'b1;
        collect(1, 20);
        n_cmp++; if (got_n != 1 || got_pc[0] !== 16'd4) begin
            n_err++; $display("FAIL br_first: got n=%0d pc=%h required 1/0004", got_n, got_pc[0]); end
    endtask

    task automatic test_redirect(input logic twice);
        logic [15:0] exp_t;
        gnt_rand = 0; lat_min = 4; lat_max = 4;
        do_reset();
        ready = 1'b1;
        @(negedge clk);              // request for 0 granted, response pending
        #1;
        br = 1'b1; br_pc = 16'h0020; br_off = 4'd3;
        exp_t = 16'h0024;
        if (twice) begin
            @(posedge clk);
            #1;
            br_pc = 16'h0040; br_off = 4'hF;
            exp_t = 16'h0040;
        end
        @(posedge clk);
        #1 br = 1'b0;
        @(negedge clk);
        n_cmp++; if (fpc_a !== exp_t) begin n_err++; $display("FAIL redir_pc: got %h required %h", fpc_a, exp_t); end
        n_cmp++; if (bus_a.imem_req !== 1'b0) begin n_err++; $display("FAIL redir_wait: got req=%b required 0", bus_a.imem_req); end
        collect(1, 40);
        n_cmp++; if (got_n != 1 || got_pc[0] !== exp_t || got_ins[0] !== f(exp_t)) begin
            n_err++; $display("FAIL redir_first: got n=%0d pc=%h instr=%h required pc=%h instr=%h", got_n, got_pc[0], got_ins[0], exp_t, f(exp_t)); end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_reset_midop();
        int c;
        gnt_rand = 0; lat_min = 1; lat_max = 1;
        do_reset();
        for (c = 0; c < 30; c++) begin
            @(negedge clk);
            if (q_pc.size() == 3 && out_m) break;
        end
        n_cmp++;
        if (c == 30) begin
            n_err++; $display("FAIL midop_setup: got timeout required 3 queued + 1 outstanding");
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL midop_valid: got %b required 0", bus_a.instr_valid); end
        n_cmp++; if (bus_a.imem_req !== 1'b0) begin n_err++; $display("FAIL midop_req: got %b required 0", bus_a.imem_req); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        rvalid = 1'b1;               // spurious response in first cycle after release
        rdata  = 16'hDEAD;
        ready  = 1'b1;
        @(negedge clk);
        collect(1, 20);
        n_cmp++; if (got_n != 1 || got_pc[0] !== 16'h0000 || got_ins[0] !== 16'h1000) begin
            n_err++; $display("FAIL midop_first: got n=%0d pc=%h instr=%h required 0000/1000", got_n, got_pc[0], got_ins[0]); end
    endtask

    task automatic test_pc_wrap();
        logic [15:0] wpc[3];
        logic [15:0] wins[3];
        int n;
        do_reset();
        n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            @(negedge clk);
            if (bus_w.instr_valid) begin
                wpc[n] = bus_w.instr_pc; wins[n] = bus_w.instr; n++;
            end
        end
        n_cmp++;
        if (n != 3) begin
            n_err++; $display("FAIL wrap_count: got %0d required 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [15:0] e;
                e = 16'(16'hFFFE + i);
                n_cmp++;
                if (wpc[i] !== e || wins[i] !== f(e)) begin
                    n_err++; $display("FAIL wrap[%0d]: got pc=%h instr=%h required pc=%h instr=%h", i, wpc[i], wins[i], e, f(e));
                end
            end
        end
    endtask

    task automatic test_random(input int cycles);
        logic exp_req;
        do_reset();
        gnt_rand = 1; lat_min = 1; lat_max = 4;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            ready  = ($urandom_range(3, 0) != 0);
            br     = ($urandom_range(15, 0) == 0);
            br_pc  = 16'($urandom);
            br_off = 4'($urandom);
            @(negedge clk);
            exp_req = !out_m && (q_pc.size() < DEPTH) && !br;
            n_cmp++;
            if (bus_a.instr_valid !== (q_pc.size() != 0)) begin
                n_err++; $display("FAIL rnd_valid @%0d: got %b required %b", c, bus_a.instr_valid, q_pc.size() != 0);
            end
            if (q_pc.size() != 0) begin
                n_cmp++;
                if (bus_a.instr_pc !== q_pc[0] || bus_a.instr !== f(q_pc[0])) begin
                    n_err++; $display("FAIL rnd_head @%0d: got pc=%h instr=%h required pc=%h instr=%h", c, bus_a.instr_pc, bus_a.instr, q_pc[0], f(q_pc[0]));
                end
            end
            n_cmp++;
            if (bus_a.imem_req !== exp_req) begin
                n_err++; $display("FAIL rnd_req @%0d: got %b required %b", c, bus_a.imem_req, exp_req);
            end
            n_cmp++;
            if (fpc_a !== pc_m || bus_a.imem_addr !== pc_m) begin
                n_err++; $display("FAIL rnd_pc @%0d: got fetch_pc=%h addr=%h required %h", c, fpc_a, bus_a.imem_addr, pc_m);
            end
        end
        @(posedge clk);
        #1 br = 1'b0;
        gnt_rand = 0;
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_branch();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_reset_midop();
        test_pc_wrap();
        test_random(2000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage for the 16-bit MIPS core. It replaces the bare program counter and incrementer.
- Holds the fetch PC and issues one-at-a-time requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry prefetch queue. Presents them to decode with a valid/ready handshake.
- On a taken branch it computes the target (branch PC + 1 + sign-extended offset), flushes the queue and redirects the fetch PC.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width (word addressed).
- INSTR_W, 16, instruction width.
- OFFSET_W, 4, branch offset field width; sign-extended to ADDR_W.
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; equals fetch_pc.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid; at least 1 cycle after gnt.
- imem_rdata  in  INSTR_W  instruction word returned.
- instr_valid  out  1  queue head valid.
- instr  out  INSTR_W  queue head instruction.
- instr_pc  out  ADDR_W  PC of the queue head.
- instr_ready  in  1  decode accepts the head.
- branch_taken  in  1  redirect strobe, one cycle.
- branch_pc  in  ADDR_W  PC of the branch instruction.
- branch_offset  in  OFFSET_W  signed word offset.
- fetch_pc  out  ADDR_W  current fetch PC, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC.
  - Queue count=0, rd/wr pointers=0.
  - outstanding=0, discard=0, imem_req=0, instr_valid=0.
  - instr and instr_pc don't-care while instr_valid=0.
  - Reset mid-operation abandons any in-flight request. imem_rvalid in the first cycle after release is ignored.
- Request issue:
  - imem_req=1 when outstanding=0 and count<DEPTH, and branch_taken=0 that cycle.
  - imem_addr is held stable until gnt.
  - On req&gnt: outstanding<=1 and fetch_pc<=fetch_pc+1, modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
  - At most one request is outstanding.
- Response:
  - On imem_rvalid with outstanding=1 and discard=0, push {pc_of_request, imem_rdata} and clear outstanding.
  - pc_of_request is latched at grant.
  - A request is never issued without a free slot, so a push never overflows.
- Dequeue:
  - The head is shown combinationally from queue storage.
  - instr_valid = (count≠0).
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (branch_taken=1):
  - target = branch_pc + 1 + sext(branch_offset), modulo 2^ADDR_W.
  - fetch_pc<=target.
  - A pop handshaking in the same cycle completes; then all entries are flushed (count<=0, pointers reset).
  - imem_req is 0 that cycle. An un-granted request is withdrawn.
  - If outstanding=1 and no rvalid that cycle: discard<=1. The next rvalid is dropped and clears outstanding and discard.
  - If rvalid arrives in the redirect cycle, it is dropped and outstanding clears.
  - New fetch from target may issue the cycle after redirect.
- Back-to-back branch_taken: the latest target wins; discard stays set until the stale response returns.
- Latency: with immediate gnt and rvalid one cycle later, the first instr_valid is 2 cycles after reset release. Sustained throughput is 1 instruction per 2 cycles (single outstanding).
- fetch_pc, imem_addr and queue contents change only on clk edges or reset.

Test Plan:
- Reset RESET_PC=0, gnt tied 1, rvalid 1 cycle after gnt, rdata=0x1000+addr, instr_ready=1 -> instr/instr_pc sequence {0x1000,0},{0x1001,1},{0x1002,2}; first instr_valid 2 cycles after release.
- instr_ready=0, DEPTH=4 -> after 4 pushes imem_req stays 0 and fetch_pc=4. Raising ready drains 0..3 in order and fetching resumes at 4.
- branch_taken with branch_pc=5, offset=4'b1110 (-2) -> fetch_pc=4, queue empty next cycle, next imem_addr=4.
- Redirect while a granted request is outstanding -> its later rvalid data is never presented; first instr after redirect has instr_pc=target.
- RESET_PC=0xFFFE, sequential fetch -> instr_pc 0xFFFE, 0xFFFF, 0x0000.
- Assert rst_n=0 with 3 entries queued and one request outstanding -> instr_valid=0 and imem_req=0 immediately. After release, the first instr_pc=RESET_PC.
